// File: rtl/button_debounce.sv
// Push-button conditioning: two-flop synchroniser, per-channel stability FSM,
// registered debounced level plus single-cycle press/release strobes.
module button_debounce #(
  parameter int unsigned N_BTN     = 4,
  parameter int unsigned DB_CYCLES = 1250000,
  parameter int unsigned CNT_W     = 21
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  typedef enum logic [1:0] {StIdle, StChkHi, StHeld, StChkLo} state_t;

  // Terminal count: DB_CYCLES consecutive stable cycles spent in a CHK state.
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

  logic [N_BTN-1:0] sync1_q, sync2_q;
  state_t           state_q [N_BTN];
  state_t           state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;

  // Two-flop synchroniser; the FSMs only ever look at sync2_q.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-channel state, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next-state logic; strobes default low so they last exactly one cycle.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        StIdle: begin
          if (sync2_q[i]) begin
            state_d[i] = StChkHi;
            cnt_d[i]   = '0;
          end
        end
        StChkHi: begin
          if (!sync2_q[i]) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = StHeld;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        StHeld: begin
          if (!sync2_q[i]) begin
            state_d[i] = StChkLo;
            cnt_d[i]   = '0;
          end
        end
        StChkLo: begin
          if (sync2_q[i]) begin
            state_d[i] = StHeld;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i]   = StIdle;
            cnt_d[i]     = '0;
            level_d[i]   = 1'b0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = StIdle;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule
